// File: rtl/fifo_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_xfer_ctrl
//  Purpose  : Sequences F0 -> A0 -> F1 byte moves for one UDB datapath and
//             raises the DMA requests that keep F0 fed and F1 drained.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_xfer_ctrl #(
    parameter int         LEN_W    = 16,
    parameter logic [2:0] CS_NOP   = 3'd0,
    parameter logic [2:0] CS_LOAD  = 3'd1,
    parameter logic [2:0] CS_STORE = 3'd2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             f0_not_empty,
    input  logic             f0_not_full,
    input  logic             f1_not_full,
    input  logic             f1_not_empty,
    input  logic             f0_wr,
    output logic [2:0]       cs_addr,
    output logic             drq_f0_in,
    output logic             drq_f1_out,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_STORE = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [2:0]       r_cs_addr;
    logic [2:0]       w_next_cs;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_req_cnt;
    logic [LEN_W-1:0] w_count_inc;
    logic             w_req_open;
    logic             w_accept_start;

    assign w_count_inc    = r_count + LEN_W'(1);
    assign w_req_open     = (r_req_cnt < r_len);
    assign w_accept_start = (r_state == c_ST_IDLE) && start;

    // Next-state logic; abort overrides everything except an idle FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? c_ST_DONE : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (f0_not_empty && f1_not_full) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = c_ST_STORE;
            end
            c_ST_STORE: begin
                w_next_state = (w_count_inc == r_len) ? c_ST_DRAIN : c_ST_WAIT;
            end
            c_ST_DRAIN: begin
                if (!f1_not_empty) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
        if (abort && (r_state != c_ST_IDLE)) begin
            w_next_state = c_ST_IDLE;
        end
    end

    always_comb begin
        w_next_cs = CS_NOP;
        case (w_next_state)
            c_ST_LOAD:  w_next_cs = CS_LOAD;
            c_ST_STORE: w_next_cs = CS_STORE;
            default:    w_next_cs = CS_NOP;
        endcase
    end

    // Outputs are registered alongside the state so they follow it exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cs_addr <= CS_NOP;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cs_addr <= w_next_cs;
            r_busy    <= (w_next_state != c_ST_IDLE);
            r_done    <= (w_next_state == c_ST_DONE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len     <= '0;
            r_count   <= '0;
            r_req_cnt <= '0;
        end else if (w_accept_start) begin
            r_len     <= len;
            r_count   <= '0;
            r_req_cnt <= '0;
        end else begin
            if ((r_state == c_ST_STORE) && !abort) begin
                r_count <= w_count_inc;
            end
            // Surplus bus writes beyond the programmed length are ignored.
            if (r_busy && f0_wr && w_req_open) begin
                r_req_cnt <= r_req_cnt + LEN_W'(1);
            end
        end
    end

    assign cs_addr    = r_cs_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign count      = r_count;
    assign drq_f0_in  = r_busy && w_req_open && f0_not_full;
    assign drq_f1_out = r_busy && f1_not_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_xfer_ctrl
//  Purpose  : Bench for fifo_xfer_ctrl with a behavioural F0/A0/F1 datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_xfer_ctrl;

    localparam logic [2:0] CS_NOP   = 3'd0;
    localparam logic [2:0] CS_LOAD  = 3'd1;
    localparam logic [2:0] CS_STORE = 3'd2;

    logic        clock = 1'b0;
    logic        reset, start, abort, f0_wr;
    logic [15:0] len;
    logic        f0_not_empty, f0_not_full, f1_not_full, f1_not_empty;
    logic [2:0]  cs_addr;
    logic        drq_f0_in, drq_f1_out, busy, done;
    logic [15:0] count;

    fifo_xfer_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .len(len), .abort(abort),
        .f0_not_empty(f0_not_empty), .f0_not_full(f0_not_full),
        .f1_not_full(f1_not_full), .f1_not_empty(f1_not_empty), .f0_wr(f0_wr),
        .cs_addr(cs_addr), .drq_f0_in(drq_f0_in), .drq_f1_out(drq_f1_out),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] len;
        logic [15:0] exp_count;
        int          exp_loads;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] f0_q[$], f1_q[$], sb[$], src_q[$];
    logic [7:0] a0, pend_wdata;
    logic [2:0] pend_cs, prev_cs;
    logic       pend_wr, pend_rd, auto_wr, rd_en;
    int         force_wr, load_cnt, store_cnt, done_cnt, seq_err, early_done, drq_seen;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        f0_q.delete(); f1_q.delete(); sb.delete(); src_q.delete();
        pend_wr = 1'b0; pend_rd = 1'b0; pend_cs = CS_NOP; prev_cs = CS_NOP;
        force_wr = 0; f0_wr = 1'b0; a0 = 8'h00;
        load_cnt = 0; store_cnt = 0; seq_err = 0; early_done = 0; drq_seen = 0;
    endtask

    // One clock: apply the datapath effects of the edge just passed, drive
    // status, then sample the DUT and decide this cycle's bus activity.
    task automatic step();
        logic       prev_ne;
        logic [7:0] got;
        @(negedge clock);
        prev_ne = (f0_q.size() != 0);
        if (pend_rd) begin
            if (f1_q.size() == 0 || sb.size() == 0) begin
                check("f1_read_nonempty", 32'(f1_q.size()), 32'(1));
            end else begin
                got = f1_q.pop_front();
                check("f1_data", 32'(got), 32'(sb.pop_front()));
            end
        end
        if (pend_cs == CS_LOAD) begin
            if (f0_q.size() == 0) check("f0_pop_nonempty", 32'(0), 32'(1));
            else a0 = f0_q.pop_front();
        end
        if (pend_cs == CS_STORE) f1_q.push_back(a0);
        if (pend_wr && f0_q.size() < 4) f0_q.push_back(pend_wdata);
        f0_not_empty = prev_ne;
        f0_not_full  = (f0_q.size() < 4);
        f1_not_full  = (f1_q.size() < 4);
        f1_not_empty = (f1_q.size() != 0);
        #1;
        if (prev_cs == CS_LOAD && cs_addr != CS_STORE) seq_err++;
        if (prev_cs == CS_STORE && cs_addr != CS_NOP) seq_err++;
        prev_cs = cs_addr;
        pend_cs = cs_addr;
        if (cs_addr == CS_LOAD) load_cnt++;
        if (cs_addr == CS_STORE) store_cnt++;
        if (done) begin
            done_cnt++;
            if (f1_q.size() != 0) early_done++;
        end
        if (drq_f0_in) drq_seen++;
        pend_wr = 1'b0;
        if (force_wr > 0) begin
            force_wr--;
            pend_wr = 1'b1;
            pend_wdata = 8'($urandom_range(255));
        end else if (auto_wr && drq_f0_in && src_q.size() != 0) begin
            pend_wr = 1'b1;
            pend_wdata = src_q.pop_front();
        end
        if (pend_wr) sb.push_back(pend_wdata);
        f0_wr = pend_wr;
        pend_rd = rd_en && drq_f1_out;
    endtask

    task automatic start_xfer(input logic [15:0] n);
        len = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check("done_pulses", 32'(done_cnt - d0), 32'(1));
    endtask

    task automatic fill_src(input int n);
        for (int j = 0; j < n; j++) src_q.push_back(8'($urandom_range(255)));
    endtask

    initial begin
        int d0;
        int n;
        vecs[0] = '{16'd4,  16'd4,  4};
        vecs[1] = '{16'd1,  16'd1,  1};
        vecs[2] = '{16'd3,  16'd3,  3};
        vecs[3] = '{16'd9,  16'd9,  9};
        vecs[4] = '{16'd16, 16'd16, 16};

        reset = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
        auto_wr = 1'b0; rd_en = 1'b0; done_cnt = 0;
        clear_model();
        step(); step();
        check("rst_cs_addr", 32'(cs_addr), 32'(CS_NOP));
        check("rst_drq_f0", 32'(drq_f0_in), 32'(0));
        check("rst_drq_f1", 32'(drq_f1_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        reset = 1'b0;
        step();

        // Table-driven transfers; vector 0 carries the fixed data pattern.
        for (int i = 0; i < 5; i++) begin
            clear_model();
            if (i == 0) begin
                src_q.push_back(8'hFF); src_q.push_back(8'h88);
                src_q.push_back(8'h44); src_q.push_back(8'h11);
            end else begin
                fill_src(int'(vecs[i].len));
            end
            auto_wr = 1'b1; rd_en = 1'b1;
            start_xfer(vecs[i].len);
            run_to_done(400);
            check("vec_count", 32'(count), 32'(vecs[i].exp_count));
            check("vec_loads", 32'(load_cnt), 32'(vecs[i].exp_loads));
            check("vec_stores", 32'(store_cnt), 32'(vecs[i].exp_loads));
            check("vec_cs_seq_err", 32'(seq_err), 32'(0));
            check("vec_early_done", 32'(early_done), 32'(0));
            check("vec_sb_empty", 32'(sb.size()), 32'(0));
            check("vec_busy_after", 32'(busy), 32'(0));
        end

        // Backpressure: F1 is never read until it has filled.
        clear_model();
        fill_src(6);
        auto_wr = 1'b1; rd_en = 1'b0;
        start_xfer(16'd6);
        n = 0;
        while (store_cnt < 4 && n < 200) begin step(); n++; end
        for (int k = 0; k < 10; k++) step();
        check("bp_cs_hold", 32'(cs_addr), 32'(CS_NOP));
        check("bp_drq_f1", 32'(drq_f1_out), 32'(1));
        check("bp_busy", 32'(busy), 32'(1));
        check("bp_stores", 32'(store_cnt), 32'(4));
        rd_en = 1'b1;
        run_to_done(400);
        check("bp_count", 32'(count), 32'(6));
        check("bp_sb_empty", 32'(sb.size()), 32'(0));

        // Request limiting: five unconditional bus writes against len=2.
        clear_model();
        auto_wr = 1'b0; rd_en = 1'b1;
        force_wr = 5;
        start_xfer(16'd2);
        step(); step();
        check("rl_drq_dropped", 32'(drq_f0_in), 32'(0));
        drq_seen = 0;
        run_to_done(200);
        check("rl_drq_stays_low", 32'(drq_seen), 32'(0));
        check("rl_loads", 32'(load_cnt), 32'(2));
        check("rl_count", 32'(count), 32'(2));

        // Zero length: straight to DONE with no datapath activity.
        clear_model();
        d0 = done_cnt;
        start_xfer(16'd0);
        check("zl_busy", 32'(busy), 32'(1));
        check("zl_done", 32'(done), 32'(1));
        check("zl_cs", 32'(cs_addr), 32'(CS_NOP));
        check("zl_drq_f0", 32'(drq_f0_in), 32'(0));
        step();
        check("zl_busy_fall", 32'(busy), 32'(0));
        check("zl_done_once", 32'(done_cnt - d0), 32'(1));
        check("zl_count", 32'(count), 32'(0));

        // Abort in the WAIT that follows the third STORE.
        clear_model();
        fill_src(8);
        auto_wr = 1'b1; rd_en = 1'b1;
        start_xfer(16'd8);
        n = 0;
        while (store_cnt < 3 && n < 200) begin step(); n++; end
        step();
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'(0));
        check("ab_cs", 32'(cs_addr), 32'(CS_NOP));
        check("ab_count", 32'(count), 32'(3));
        step(); step(); step();
        check("ab_no_done", 32'(done_cnt - d0), 32'(0));
        clear_model();
        fill_src(1);
        start_xfer(16'd1);
        run_to_done(200);
        check("ab_restart_count", 32'(count), 32'(1));
        check("ab_restart_sb", 32'(sb.size()), 32'(0));

        // Asynchronous reset while the FSM is in LOAD.
        clear_model();
        fill_src(4);
        start_xfer(16'd4);
        n = 0;
        while (cs_addr != CS_LOAD && n < 100) begin step(); n++; end
        check("rs_reached_load", 32'(cs_addr), 32'(CS_LOAD));
        reset = 1'b1;
        #1;
        check("rs_cs_async", 32'(cs_addr), 32'(CS_NOP));
        check("rs_busy_async", 32'(busy), 32'(0));
        check("rs_drq_f0_async", 32'(drq_f0_in), 32'(0));
        check("rs_count_async", 32'(count), 32'(0));
        start = 1'b1; len = 16'd3;
        step(); step();
        check("rs_start_ignored", 32'(busy), 32'(0));
        check("rs_done_low", 32'(done), 32'(0));
        start = 1'b0;
        reset = 1'b0;
        clear_model();
        step();
        fill_src(2);
        start_xfer(16'd2);
        run_to_done(200);
        check("rs_recover_count", 32'(count), 32'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
